// File: rtl/mu0_mem_arbiter_if.sv
// CPU and host request/acknowledge bundle for mu0_mem_arbiter.
// The arbiter takes the slave modport; requesters drive the master modport.
interface mu0_mem_arbiter_if #(
    parameter int AW = 12,
    parameter int DW = 16
) ();
    logic          cpu_req;
    logic          cpu_rnw;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;

    logic          host_req;
    logic          host_rnw;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_ack;
    logic [DW-1:0] host_rdata;

    modport slave (
        input  cpu_req, cpu_rnw, cpu_addr, cpu_wdata,
        input  host_req, host_rnw, host_addr, host_wdata,
        output cpu_ack, cpu_rdata, host_ack, host_rdata
    );

    modport master (
        output cpu_req, cpu_rnw, cpu_addr, cpu_wdata,
        output host_req, host_rnw, host_addr, host_wdata,
        input  cpu_ack, cpu_rdata, host_ack, host_rdata
    );
endinterface

// File: rtl/mu0_mem_arbiter.sv
// Two-port (CPU/host) arbiter in front of the single-ported MU0 memory.
// Define MU0_ARB_RR_EN for round-robin arbitration; otherwise the CPU has fixed priority.
module mu0_mem_arbiter #(
    parameter int AW = 12,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    mu0_mem_arbiter_if.slave bus,
    output logic          MEMrq,
    output logic          RnW,
    output logic [AW-1:0] addr,
    inout  wire  [DW-1:0] data,
    output logic          busy,
    output logic          owner
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_ACK    = 2'd2;

    logic [1:0]    r_state;
    logic          r_memrq;
    logic          r_rnw;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          r_owner;
    logic          r_busy;
    logic          r_cpu_ack;
    logic          r_host_ack;
    logic [DW-1:0] r_cpu_rdata;
    logic [DW-1:0] r_host_rdata;
`ifdef MU0_ARB_RR_EN
    logic          r_rr_host_last;
`endif

    logic          w_arb_en;
    logic          w_cpu_elig;
    logic          w_host_elig;
    logic          w_grant;
    logic          w_grant_host;
    logic          w_sel_rnw;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;
    logic          w_drive;

    // Arbitration: the port being acked is excluded from its own ACK cycle
    always_comb begin
        w_arb_en     = 1'b0;
        w_grant_host = 1'b0;
        case (r_state)
            ST_IDLE: w_arb_en = 1'b1;
            ST_ACK:  w_arb_en = 1'b1;
            default: w_arb_en = 1'b0;
        endcase
        w_cpu_elig  = w_arb_en && bus.cpu_req  && !((r_state == ST_ACK) && !r_owner);
        w_host_elig = w_arb_en && bus.host_req && !((r_state == ST_ACK) &&  r_owner);
        w_grant     = w_cpu_elig || w_host_elig;
`ifdef MU0_ARB_RR_EN
        if (w_cpu_elig && w_host_elig) begin
            w_grant_host = !r_rr_host_last;
        end else begin
            w_grant_host = w_host_elig;
        end
`else
        if (w_cpu_elig) begin
            w_grant_host = 1'b0;
        end else begin
            w_grant_host = w_host_elig;
        end
`endif
    end

    // Request fields of the winning port
    always_comb begin
        w_sel_rnw   = bus.cpu_rnw;
        w_sel_addr  = bus.cpu_addr;
        w_sel_wdata = bus.cpu_wdata;
        if (w_grant_host) begin
            w_sel_rnw   = bus.host_rnw;
            w_sel_addr  = bus.host_addr;
            w_sel_wdata = bus.host_wdata;
        end else begin
            w_sel_rnw   = bus.cpu_rnw;
            w_sel_addr  = bus.cpu_addr;
            w_sel_wdata = bus.cpu_wdata;
        end
    end

    // FSM and registered memory bus; request fields are captured only at the grant edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_memrq <= 1'b0;
            r_rnw   <= 1'b1;
            r_addr  <= '0;
            r_wdata <= '0;
            r_owner <= 1'b0;
            r_busy  <= 1'b0;
`ifdef MU0_ARB_RR_EN
            r_rr_host_last <= 1'b1;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_ACK: begin
                    if (w_grant) begin
                        r_state <= ST_ACCESS;
                        r_memrq <= 1'b1;
                        r_rnw   <= w_sel_rnw;
                        r_addr  <= w_sel_addr;
                        r_wdata <= w_sel_wdata;
                        r_owner <= w_grant_host;
                        r_busy  <= 1'b1;
`ifdef MU0_ARB_RR_EN
                        r_rr_host_last <= w_grant_host;
`endif
                    end else begin
                        r_state <= ST_IDLE;
                        r_memrq <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    r_state <= ST_ACK;
                    r_memrq <= 1'b0;
                    r_busy  <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_memrq <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Completion pulse and read-data capture at the edge ending ACCESS
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cpu_ack    <= 1'b0;
            r_host_ack   <= 1'b0;
            r_cpu_rdata  <= '0;
            r_host_rdata <= '0;
        end else if (r_state == ST_ACCESS) begin
            r_cpu_ack  <= !r_owner;
            r_host_ack <= r_owner;
            if (r_rnw && r_owner) begin
                r_host_rdata <= data;
            end else if (r_rnw) begin
                r_cpu_rdata <= data;
            end else begin
                r_cpu_rdata <= r_cpu_rdata;
            end
        end else begin
            r_cpu_ack  <= 1'b0;
            r_host_ack <= 1'b0;
        end
    end

    assign w_drive = (r_state == ST_ACCESS) && !r_rnw;
    assign data    = w_drive ? r_wdata : {DW{1'bz}};

    assign MEMrq          = r_memrq;
    assign RnW            = r_rnw;
    assign addr           = r_addr;
    assign busy           = r_busy;
    assign owner          = r_owner;
    assign bus.cpu_ack    = r_cpu_ack;
    assign bus.host_ack   = r_host_ack;
    assign bus.cpu_rdata  = r_cpu_rdata;
    assign bus.host_rdata = r_host_rdata;
endmodule

// File: tb/tb_mu0_mem_arbiter.sv
// Scoreboard bench for mu0_mem_arbiter: a transaction-level reference model queues
// expected bus cycles and acks; a negedge monitor pops and compares them.
module tb_mu0_mem_arbiter;
    localparam int AW = 12;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mu0_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    logic          MEMrq;
    logic          RnW;
    logic [AW-1:0] addr;
    wire  [DW-1:0] mem_data;
    logic          busy;
    logic          owner;

    logic          req_s   [2];
    logic          rnw_s   [2];
    logic [AW-1:0] addr_s  [2];
    logic [DW-1:0] wdata_s [2];

    assign bus.cpu_req    = req_s[0];
    assign bus.cpu_rnw    = rnw_s[0];
    assign bus.cpu_addr   = addr_s[0];
    assign bus.cpu_wdata  = wdata_s[0];
    assign bus.host_req   = req_s[1];
    assign bus.host_rnw   = rnw_s[1];
    assign bus.host_addr  = addr_s[1];
    assign bus.host_wdata = wdata_s[1];

    mu0_mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .MEMrq (MEMrq),
        .RnW   (RnW),
        .addr  (addr),
        .data  (mem_data),
        .busy  (busy),
        .owner (owner)
    );

    // Memory bus model: combinational read data, a zero keeper whenever nobody else drives
    logic [DW-1:0] mem    [0:(1<<AW)-1];
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    logic          mem_init = 1'b0;
    assign mem_data = (MEMrq && !RnW) ? {DW{1'bz}} : ((MEMrq && RnW) ? mem[addr] : {DW{1'b0}});

    function automatic logic [DW-1:0] init_val(input int i);
        if (i == 29) return DW'(21);
        else if (i >= 24 && i <= 31) return DW'(32'h1000 + i);
        else return '0;
    endfunction

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= init_val(i);
            mem_init <= 1'b1;
        end else if (MEMrq && !RnW) begin
            mem[addr] <= mem_data;
        end
    end

    typedef struct {
        int            port;
        logic          rnw;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic [DW-1:0] rd;
        int            cyc;
    } xact_t;

    xact_t acc_q[$];
    xact_t ack_q[$];
    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;
    int next_ok = 0;
    int excl_edge = -1;
    int excl_port = 0;
    int last_port = 1;
    logic          exp_owner = 1'b0;
    logic          exp_rnw = 1'b1;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_rd [2];
    bit            shadow_init = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: one grant per free slot, acked port sits out one slot, access then ack
    always @(posedge clk) begin : ref_model
        bit    e0;
        bit    e1;
        int    win;
        xact_t t;
        cyc++;
        if (!shadow_init) begin
            for (int i = 0; i < (1 << AW); i++) shadow[i] = init_val(i);
            shadow_init = 1'b1;
        end
        if (reset) begin
            acc_q.delete();
            ack_q.delete();
            next_ok   = cyc + 1;
            excl_edge = -1;
            last_port = 1;
            exp_owner = 1'b0;
            exp_rnw   = 1'b1;
            exp_addr  = '0;
            exp_rd[0] = '0;
            exp_rd[1] = '0;
        end else if (cyc >= next_ok) begin
            e0  = req_s[0] && !(cyc == excl_edge && excl_port == 0);
            e1  = req_s[1] && !(cyc == excl_edge && excl_port == 1);
            win = -1;
            if (e0 && e1) begin
`ifdef MU0_ARB_RR_EN
                win = 1 - last_port;
`else
                win = 0;
`endif
            end else if (e0) win = 0;
            else if (e1) win = 1;
            if (win >= 0) begin
                t.port = win;
                t.rnw  = rnw_s[win];
                t.a    = addr_s[win];
                t.wd   = wdata_s[win];
                t.rd   = shadow[t.a];
                t.cyc  = cyc;
                acc_q.push_back(t);
                t.cyc  = cyc + 1;
                ack_q.push_back(t);
                if (!t.rnw) shadow[t.a] = t.wd;
                next_ok   = cyc + 2;
                excl_edge = cyc + 2;
                excl_port = win;
                last_port = win;
                exp_owner = (win == 1);
                exp_rnw   = t.rnw;
                exp_addr  = t.a;
            end
        end
    end

    // Monitor: compare every visible output against the queued expectations
    always @(negedge clk) begin : monitor
        bit            exp_acc;
        bit            exp_ack;
        xact_t         a;
        xact_t         k;
        logic [DW-1:0] exp_bus;
        if (cyc > 0) begin
            while (acc_q.size() > 0 && acc_q[0].cyc < cyc) begin
                chk("access_slot", 32'(cyc), 32'(acc_q[0].cyc));
                a = acc_q.pop_front();
            end
            while (ack_q.size() > 0 && ack_q[0].cyc < cyc) begin
                chk("ack_slot", 32'(cyc), 32'(ack_q[0].cyc));
                k = ack_q.pop_front();
            end
            exp_acc = (acc_q.size() > 0) && (acc_q[0].cyc == cyc);
            exp_ack = (ack_q.size() > 0) && (ack_q[0].cyc == cyc);
            chk("MEMrq", 32'(MEMrq), 32'(exp_acc));
            chk("busy", 32'(busy), 32'(exp_acc || exp_ack));
            chk("owner", 32'(owner), 32'(exp_owner));
            chk("RnW", 32'(RnW), 32'(exp_rnw));
            chk("addr", 32'(addr), 32'(exp_addr));
            exp_bus = '0;
            if (exp_acc) begin
                a = acc_q.pop_front();
                exp_bus = a.rnw ? a.rd : a.wd;
            end
            chk("data_bus", 32'(mem_data), 32'(exp_bus));
            if (exp_ack) begin
                k = ack_q.pop_front();
                chk("cpu_ack", 32'(bus.cpu_ack), 32'(k.port == 0));
                chk("host_ack", 32'(bus.host_ack), 32'(k.port == 1));
                if (k.rnw) exp_rd[k.port] = k.rd;
            end else begin
                chk("cpu_ack_idle", 32'(bus.cpu_ack), 32'(0));
                chk("host_ack_idle", 32'(bus.host_ack), 32'(0));
            end
            chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(exp_rd[0]));
            chk("host_rdata", 32'(bus.host_rdata), 32'(exp_rd[1]));
        end
    end

    // One access on port p; fields are scrambled (and req maybe dropped) once it is granted
    task automatic do_access(input int p, input logic rnw, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input bit keep);
        int   n = 0;
        bit   seen = 1'b0;
        logic ack;
        rnw_s[p]   = rnw;
        addr_s[p]  = a;
        wdata_s[p] = d;
        req_s[p]   = 1'b1;
        forever begin
            @(negedge clk);
            n++;
            ack = (p == 0) ? bus.cpu_ack : bus.host_ack;
            if (ack) break;
            if (n > 20) begin
                n_checks++;
                $display("FAIL ack_timeout port %0d: waited %0d cycles, limit 20", p, n);
                break;
            end
            if (!seen && MEMrq && (owner == (p == 1))) begin
                seen       = 1'b1;
                addr_s[p]  = AW'($urandom);
                wdata_s[p] = DW'($urandom);
                rnw_s[p]   = ~rnw_s[p];
                if ($urandom_range(0, 1) == 1) req_s[p] = 1'b0;
            end
        end
        req_s[p] = keep;
    endtask

    task automatic run_port(input int p, input int count, input bit continuous);
        int  gap;
        bit  keep;
        for (int i = 0; i < count; i++) begin
            gap  = continuous ? 0 : int'($urandom_range(0, 3));
            keep = (gap == 0) && (i != count - 1);
            do_access(p, 1'($urandom_range(0, 1)), AW'(24 + $urandom_range(0, 7)),
                      DW'($urandom), keep);
            if (!keep) repeat (gap) @(negedge clk);
        end
        req_s[p] = 1'b0;
    endtask

    initial begin
        int n;
        for (int p = 0; p < 2; p++) begin
            req_s[p]   = 1'b0;
            rnw_s[p]   = 1'b1;
            addr_s[p]  = '0;
            wdata_s[p] = '0;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        do_access(0, 1'b1, AW'(29), DW'(0), 1'b0);
        chk("cpu_read_29", 32'(bus.cpu_rdata), 32'(21));
        do_access(1, 1'b0, AW'(30), DW'(3), 1'b0);
        do_access(0, 1'b1, AW'(30), DW'(0), 1'b0);
        chk("cpu_read_30", 32'(bus.cpu_rdata), 32'(3));
        repeat (2) @(negedge clk);

        rnw_s[0]   = 1'b0;
        addr_s[0]  = AW'(28);
        wdata_s[0] = DW'(7);
        req_s[0]   = 1'b1;
        n = 0;
        while (!MEMrq && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("rst_wr_granted", 32'(MEMrq), 32'(1));
        reset    = 1'b1;
        req_s[0] = 1'b0;
        @(negedge clk);
        chk("rst_MEMrq", 32'(MEMrq), 32'(0));
        chk("rst_cpu_ack", 32'(bus.cpu_ack), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_RnW", 32'(RnW), 32'(1));
        chk("rst_addr", 32'(addr), 32'(0));
        chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'(0));
        reset = 1'b0;
        @(negedge clk);
        chk("mem28_commit", 32'(mem[28]), 32'(7));

        fork
            run_port(0, 8, 1'b1);
            run_port(1, 8, 1'b1);
        join
        repeat (3) @(negedge clk);
        fork
            run_port(0, 60, 1'b0);
            run_port(1, 60, 1'b0);
        join
        repeat (5) @(negedge clk);
        for (int i = 24; i < 32; i++) chk("mem_final", 32'(mem[i]), 32'(shadow[i]));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
